// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change scheduler.
package vend_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEND   = 3'd1,
    PAYOUT = 3'd2,
    GAP    = 3'd3,
    FAULT  = 3'd4
  } state_e;

  localparam int COIN5_VAL   = 5;
  localparam int COIN10_VAL  = 10;
  localparam int CHANGE_UNIT = 5;

  // Simultaneous coin5/coin10 is illegal and is worth nothing.
  function automatic int coin_value(input logic c5, input logic c10);
    case ({c5, c10})
      2'b10:   coin_value = COIN5_VAL;
      2'b01:   coin_value = COIN10_VAL;
      default: coin_value = 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_scheduler_if.sv
// Bus between the scheduler and the coin acceptor / dispense actuator / change hopper.
interface vend_change_scheduler_if #(parameter int CW = 6);

  logic          coin5;
  logic          coin10;
  logic          cancel;
  logic          change_ack;
  logic          coin_accept;
  logic          dispense;
  logic          change_req;
  logic [CW-1:0] credit;
  logic          busy;
  logic          fault;

  modport master (
    output coin5, coin10, cancel, change_ack,
    input  coin_accept, dispense, change_req, credit, busy, fault
  );

  modport slave (
    input  coin5, coin10, cancel, change_ack,
    output coin_accept, dispense, change_req, credit, busy, fault
  );

endinterface

// File: rtl/vend_payout_ctrl.sv
// Change hopper handshake: holds change_req from start until ack or timeout.
module vend_payout_ctrl
  import vend_pkg::*;
#(
  parameter int CW             = 6,
  parameter int HOPPER_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [CW-1:0] i_amount,
  input  logic          i_change_ack,
  output logic          o_change_req,
  output logic          o_done,
  output logic          o_timeout,
  output logic [CW-1:0] o_next_amount
);

  localparam int            TW      = $clog2(HOPPER_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(HOPPER_TIMEOUT - 1);
  localparam logic [CW-1:0] UNIT    = CW'(CHANGE_UNIT);

  logic          r_active;
  logic [TW-1:0] r_count;
  logic          w_done;
  logic          w_timeout;

  assign w_done    = r_active && i_change_ack;
  // Timeout fires on the cycle that would make the wait count reach HOPPER_TIMEOUT.
  assign w_timeout = r_active && !i_change_ack && (r_count == TO_LAST);

  // Request flag and wait counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active <= 1'b0;
      r_count  <= {TW{1'b0}};
    end else if (i_start) begin
      r_active <= 1'b1;
      r_count  <= {TW{1'b0}};
    end else if (w_done || w_timeout) begin
      r_active <= 1'b0;
      r_count  <= {TW{1'b0}};
    end else if (r_active) begin
      r_count  <= r_count + TW'(1'b1);
    end else begin
      r_count  <= {TW{1'b0}};
    end
  end

  assign o_change_req  = r_active;
  assign o_done        = w_done;
  assign o_timeout     = w_timeout;
  assign o_next_amount = (i_amount >= UNIT) ? (i_amount - UNIT) : {CW{1'b0}};

endmodule

// File: rtl/vend_change_scheduler.sv
// Vending sequencer: credit accumulation, auto-vend, change payout, hopper fault.
// Optional VEND_COUNTER_EN adds a 16-bit wrapping dispense counter output.
module vend_change_scheduler
  import vend_pkg::*;
#(
  parameter int PRICE          = 15,
  parameter int CREDIT_MAX     = 35,
  parameter int CW             = 6,
  parameter int HOPPER_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  vend_change_scheduler_if.slave  bus
`ifdef VEND_COUNTER_EN
  ,
  output logic [15:0]             vend_count
`endif
);

  localparam logic [CW-1:0] PRICE_C   = CW'(PRICE);
  localparam logic [CW-1:0] ACCEPT_LE = CW'(CREDIT_MAX - 10);

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_credit;
  logic [CW-1:0] w_credit_next;
  logic [CW-1:0] w_coin_val;
  logic [CW-1:0] w_credit_add;
  logic [CW-1:0] w_after_vend;
  logic [CW-1:0] w_next_amount;
  logic          w_accept;
  logic          w_start;
  logic          w_done;
  logic          w_timeout;
  logic          w_change_req;

  assign w_coin_val   = CW'(coin_value(bus.coin5, bus.coin10));
  assign w_accept     = (r_state == IDLE) && (r_credit < PRICE_C) && (r_credit <= ACCEPT_LE);
  assign w_credit_add = w_accept ? (r_credit + w_coin_val) : r_credit;
  assign w_after_vend = r_credit - PRICE_C;

  // Next state, next credit and payout start.
  always_comb begin
    w_state_next  = r_state;
    w_credit_next = r_credit;
    w_start       = 1'b0;
    case (r_state)
      IDLE: begin
        w_credit_next = w_credit_add;
        if (r_credit >= PRICE_C) begin
          w_state_next = VEND;
        end else if (w_credit_add >= PRICE_C) begin
          // A completing coin beats a simultaneous cancel; the vend follows next cycle.
          w_state_next = IDLE;
        end else if (bus.cancel && (w_credit_add != {CW{1'b0}})) begin
          w_state_next = PAYOUT;
          w_start      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      VEND: begin
        w_credit_next = w_after_vend;
        if (w_after_vend != {CW{1'b0}}) begin
          w_state_next = PAYOUT;
          w_start      = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      PAYOUT: begin
        if (w_done) begin
          w_credit_next = w_next_amount;
          w_state_next  = GAP;
        end else if (w_timeout) begin
          w_state_next  = FAULT;
        end else begin
          w_state_next  = PAYOUT;
        end
      end
      GAP: begin
        if (r_credit == {CW{1'b0}}) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = PAYOUT;
          w_start      = 1'b1;
        end
      end
      FAULT: begin
        w_state_next = FAULT;
      end
      default: begin
        w_state_next  = IDLE;
        w_credit_next = {CW{1'b0}};
      end
    endcase
  end

  // State and credit registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_credit <= {CW{1'b0}};
    end else begin
      r_state  <= w_state_next;
      r_credit <= w_credit_next;
    end
  end

  vend_payout_ctrl #(
    .CW             (CW),
    .HOPPER_TIMEOUT (HOPPER_TIMEOUT)
  ) u_payout (
    .clk           (clk),
    .rst           (rst),
    .i_start       (w_start),
    .i_amount      (r_credit),
    .i_change_ack  (bus.change_ack),
    .o_change_req  (w_change_req),
    .o_done        (w_done),
    .o_timeout     (w_timeout),
    .o_next_amount (w_next_amount)
  );

`ifdef VEND_COUNTER_EN
  logic [15:0] r_vend_count;

  // Dispense pulse counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vend_count <= 16'd0;
    end else if (r_state == VEND) begin
      r_vend_count <= r_vend_count + 16'd1;
    end else begin
      r_vend_count <= r_vend_count;
    end
  end

  assign vend_count = r_vend_count;
`endif

  assign bus.coin_accept = w_accept;
  assign bus.dispense    = (r_state == VEND);
  assign bus.change_req  = w_change_req;
  assign bus.credit      = r_credit;
  assign bus.busy        = (r_state != IDLE);
  assign bus.fault       = (r_state == FAULT);

endmodule
